// File: rtl/e203_exu_trap_ctrl.sv
// Commit-stage trap controller: resolves irq/exception/mret per commit, drives CSR strobes and IFU flush.
// Latency: accept in N, all cmt_* and flush outputs registered in N+1. Optional E203_TRAP_VECTORED_EN.
// Backpressure: cmt_i_ready low from N+1 of a trap/mret until the cycle after pipe_flush_ack.
module e203_exu_trap_ctrl #(
    parameter int PC_SIZE = 32
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               cmt_i_valid,
    output logic               cmt_i_ready,
    input  logic [PC_SIZE-1:0] cmt_i_pc,
    input  logic               cmt_i_ilegl,
    input  logic               cmt_i_ebreak,
    input  logic               cmt_i_ecall,
    input  logic               cmt_i_misalgn_ld,
    input  logic               cmt_i_misalgn_st,
    input  logic [PC_SIZE-1:0] cmt_i_badaddr,
    input  logic               cmt_i_mret,

    input  logic               ext_irq_r,
    input  logic               sft_irq_r,
    input  logic               tmr_irq_r,
    input  logic               status_mie_r,
    input  logic               mie_meie_r,
    input  logic               mie_msie_r,
    input  logic               mie_mtie_r,
    input  logic [PC_SIZE-1:0] csr_mtvec_r,
    input  logic [PC_SIZE-1:0] csr_epc_r,
    input  logic               dbg_mode,

    output logic [PC_SIZE-1:0] cmt_epc,
    output logic [PC_SIZE-1:0] cmt_badaddr,
    output logic [PC_SIZE-1:0] cmt_cause,
    output logic               cmt_epc_ena,
    output logic               cmt_badaddr_ena,
    output logic               cmt_cause_ena,
    output logic               cmt_status_ena,
    output logic               cmt_mret_ena,
    output logic               cmt_instret_ena,
    output logic               nonflush_cmt_ena,

    output logic               pipe_flush_req,
    output logic [PC_SIZE-1:0] pipe_flush_pc,
    input  logic               pipe_flush_ack
);

    typedef enum logic {
        IDLE       = 1'b0,
        FLUSH_WAIT = 1'b1
    } state_t;

    state_t state;

    logic               cmt_hsk;
    logic               irq_glb_en;
    logic               irq_take;
    logic [3:0]         irq_code;
    logic               exc_take;
    logic               exc_misalgn;
    logic [3:0]         exc_code;
    logic               trap_take;
    logic [3:0]         trap_code;
    logic [PC_SIZE-1:0] trap_cause;
    logic [PC_SIZE-1:0] trap_base;
    logic [PC_SIZE-1:0] trap_target;
    logic               unused_mtvec;

    assign cmt_i_ready = (state == IDLE);
    assign cmt_hsk     = cmt_i_valid & cmt_i_ready;

    // Interrupts are masked globally by mstatus.MIE and whenever the core is in debug mode.
    assign irq_glb_en = status_mie_r & ~dbg_mode;

    always_comb begin
        irq_take = 1'b1;
        irq_code = 4'd0;
        if (irq_glb_en & ext_irq_r & mie_meie_r) begin
            irq_code = 4'd11;
        end else if (irq_glb_en & sft_irq_r & mie_msie_r) begin
            irq_code = 4'd3;
        end else if (irq_glb_en & tmr_irq_r & mie_mtie_r) begin
            irq_code = 4'd7;
        end else begin
            irq_take = 1'b0;
        end
    end

    always_comb begin
        exc_take    = 1'b1;
        exc_misalgn = 1'b0;
        exc_code    = 4'd0;
        if (cmt_i_ilegl) begin
            exc_code = 4'd2;
        end else if (cmt_i_ebreak) begin
            exc_code = 4'd3;
        end else if (cmt_i_ecall) begin
            exc_code = 4'd11;
        end else if (cmt_i_misalgn_ld) begin
            exc_code    = 4'd4;
            exc_misalgn = 1'b1;
        end else if (cmt_i_misalgn_st) begin
            exc_code    = 4'd6;
            exc_misalgn = 1'b1;
        end else begin
            exc_take = 1'b0;
        end
    end

    assign trap_take  = irq_take | exc_take;
    assign trap_code  = irq_take ? irq_code : exc_code;
    assign trap_cause = {irq_take, {(PC_SIZE-5){1'b0}}, trap_code};
    assign trap_base  = {csr_mtvec_r[PC_SIZE-1:2], 2'b00};

`ifdef E203_TRAP_VECTORED_EN
    // Vectored mode only offsets interrupts; synchronous exceptions always land on the base.
    assign trap_target = (irq_take & csr_mtvec_r[0])
                       ? trap_base + {{(PC_SIZE-6){1'b0}}, irq_code, 2'b00}
                       : trap_base;
`else
    assign trap_target = trap_base;
`endif

    assign unused_mtvec = ^csr_mtvec_r[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cmt_epc          <= '0;
            cmt_badaddr      <= '0;
            cmt_cause        <= '0;
            cmt_epc_ena      <= 1'b0;
            cmt_badaddr_ena  <= 1'b0;
            cmt_cause_ena    <= 1'b0;
            cmt_status_ena   <= 1'b0;
            cmt_mret_ena     <= 1'b0;
            cmt_instret_ena  <= 1'b0;
            nonflush_cmt_ena <= 1'b0;
            pipe_flush_req   <= 1'b0;
            pipe_flush_pc    <= '0;
        end else begin
            cmt_epc_ena      <= 1'b0;
            cmt_badaddr_ena  <= 1'b0;
            cmt_cause_ena    <= 1'b0;
            cmt_status_ena   <= 1'b0;
            cmt_mret_ena     <= 1'b0;
            cmt_instret_ena  <= 1'b0;
            nonflush_cmt_ena <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmt_hsk) begin
                        if (trap_take) begin
                            // Trapped instruction does not retire; badaddr only moves on exceptions.
                            cmt_epc_ena     <= 1'b1;
                            cmt_cause_ena   <= 1'b1;
                            cmt_status_ena  <= 1'b1;
                            cmt_badaddr_ena <= ~irq_take;
                            cmt_epc         <= cmt_i_pc;
                            cmt_cause       <= trap_cause;
                            if (!irq_take) begin
                                cmt_badaddr <= exc_misalgn ? cmt_i_badaddr : '0;
                            end
                            pipe_flush_req  <= 1'b1;
                            pipe_flush_pc   <= trap_target;
                            state           <= FLUSH_WAIT;
                        end else if (cmt_i_mret) begin
                            cmt_mret_ena     <= 1'b1;
                            cmt_instret_ena  <= 1'b1;
                            nonflush_cmt_ena <= 1'b1;
                            pipe_flush_req   <= 1'b1;
                            pipe_flush_pc    <= csr_epc_r;
                            state            <= FLUSH_WAIT;
                        end else begin
                            cmt_instret_ena  <= 1'b1;
                            nonflush_cmt_ena <= 1'b1;
                        end
                    end
                end
                FLUSH_WAIT: begin
                    if (pipe_flush_ack) begin
                        pipe_flush_req <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_e203_exu_trap_ctrl.sv
// Self-checking bench for e203_exu_trap_ctrl: directed cases then randomized commits against a priority-table model.
module tb_e203_exu_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmt_i_valid, cmt_i_ready;
    logic [31:0] cmt_i_pc, cmt_i_badaddr;
    logic        cmt_i_ilegl, cmt_i_ebreak, cmt_i_ecall, cmt_i_misalgn_ld, cmt_i_misalgn_st, cmt_i_mret;
    logic        ext_irq_r, sft_irq_r, tmr_irq_r;
    logic        status_mie_r, mie_meie_r, mie_msie_r, mie_mtie_r;
    logic [31:0] csr_mtvec_r, csr_epc_r;
    logic        dbg_mode;
    logic [31:0] cmt_epc, cmt_badaddr, cmt_cause;
    logic        cmt_epc_ena, cmt_badaddr_ena, cmt_cause_ena, cmt_status_ena;
    logic        cmt_mret_ena, cmt_instret_ena, nonflush_cmt_ena;
    logic        pipe_flush_req, pipe_flush_ack;
    logic [31:0] pipe_flush_pc;

    always #5 clk = ~clk;

    e203_exu_trap_ctrl #(.PC_SIZE(32)) dut (
        .clk(clk), .rst(rst),
        .cmt_i_valid(cmt_i_valid), .cmt_i_ready(cmt_i_ready), .cmt_i_pc(cmt_i_pc),
        .cmt_i_ilegl(cmt_i_ilegl), .cmt_i_ebreak(cmt_i_ebreak), .cmt_i_ecall(cmt_i_ecall),
        .cmt_i_misalgn_ld(cmt_i_misalgn_ld), .cmt_i_misalgn_st(cmt_i_misalgn_st),
        .cmt_i_badaddr(cmt_i_badaddr), .cmt_i_mret(cmt_i_mret),
        .ext_irq_r(ext_irq_r), .sft_irq_r(sft_irq_r), .tmr_irq_r(tmr_irq_r),
        .status_mie_r(status_mie_r), .mie_meie_r(mie_meie_r), .mie_msie_r(mie_msie_r),
        .mie_mtie_r(mie_mtie_r), .csr_mtvec_r(csr_mtvec_r), .csr_epc_r(csr_epc_r),
        .dbg_mode(dbg_mode),
        .cmt_epc(cmt_epc), .cmt_badaddr(cmt_badaddr), .cmt_cause(cmt_cause),
        .cmt_epc_ena(cmt_epc_ena), .cmt_badaddr_ena(cmt_badaddr_ena), .cmt_cause_ena(cmt_cause_ena),
        .cmt_status_ena(cmt_status_ena), .cmt_mret_ena(cmt_mret_ena),
        .cmt_instret_ena(cmt_instret_ena), .nonflush_cmt_ena(nonflush_cmt_ena),
        .pipe_flush_req(pipe_flush_req), .pipe_flush_pc(pipe_flush_pc),
        .pipe_flush_ack(pipe_flush_ack)
    );

    // Strobe order: epc, badaddr, cause, status, mret, instret, nonflush
    wire [6:0] strb = {cmt_epc_ena, cmt_badaddr_ena, cmt_cause_ena, cmt_status_ena,
                       cmt_mret_ena, cmt_instret_ena, nonflush_cmt_ena};

    typedef struct packed {
        logic [31:0] pc, badaddr, mtvec, epc;
        logic ilegl, ebreak, ecall, ld, st, mret;
        logic ext, sft, tmr, mie, meie, msie, mtie, dbg;
    } stim_t;

    typedef struct packed {
        logic        trap, irq, flush;
        logic [31:0] cause, badaddr, flush_pc;
        logic [6:0]  strb;
    } exp_t;

    int total = 0;
    int passed = 0;
    int failed = 0;
    logic [31:0] last_epc = '0;
    logic [31:0] last_cause = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: walk priority tables; first enabled entry wins.
    function automatic exp_t model(input stim_t s);
        exp_t e;
        int   irq_code [3];
        bit   irq_hit  [3];
        int   exc_code [5];
        bit   exc_hit  [5];
        logic [31:0] base;
        e = '0;
        irq_code = '{11, 3, 7};
        irq_hit  = '{s.ext & s.meie, s.sft & s.msie, s.tmr & s.mtie};
        exc_code = '{2, 3, 11, 4, 6};
        exc_hit  = '{s.ilegl, s.ebreak, s.ecall, s.ld, s.st};
        if (s.mie && !s.dbg) begin
            for (int i = 0; i < 3; i++) begin
                if (irq_hit[i] && !e.trap) begin
                    e.trap  = 1'b1;
                    e.irq   = 1'b1;
                    e.cause = 32'h8000_0000 | 32'(irq_code[i]);
                end
            end
        end
        if (!e.trap) begin
            for (int i = 0; i < 5; i++) begin
                if (exc_hit[i] && !e.trap) begin
                    e.trap    = 1'b1;
                    e.cause   = 32'(exc_code[i]);
                    e.badaddr = (i >= 3) ? s.badaddr : 32'h0;
                end
            end
        end
        base = s.mtvec & 32'hFFFF_FFFC;
        if (e.trap) begin
            e.flush    = 1'b1;
            e.flush_pc = base;
`ifdef E203_TRAP_VECTORED_EN
            if (e.irq && s.mtvec[0]) e.flush_pc = base + 32'd4 * (e.cause & 32'hF);
`endif
            e.strb = e.irq ? 7'b1011000 : 7'b1111000;
        end else if (s.mret) begin
            e.flush    = 1'b1;
            e.flush_pc = s.epc;
            e.strb     = 7'b0000111;
        end else begin
            e.strb = 7'b0000011;
        end
        return e;
    endfunction

    task automatic apply(input stim_t s);
        cmt_i_pc = s.pc;          cmt_i_badaddr = s.badaddr;
        csr_mtvec_r = s.mtvec;    csr_epc_r = s.epc;
        cmt_i_ilegl = s.ilegl;    cmt_i_ebreak = s.ebreak;   cmt_i_ecall = s.ecall;
        cmt_i_misalgn_ld = s.ld;  cmt_i_misalgn_st = s.st;   cmt_i_mret = s.mret;
        ext_irq_r = s.ext;        sft_irq_r = s.sft;         tmr_irq_r = s.tmr;
        status_mie_r = s.mie;     mie_meie_r = s.meie;       mie_msie_r = s.msie;
        mie_mtie_r = s.mtie;      dbg_mode = s.dbg;
    endtask

    // Called #1 after a posedge with the DUT in IDLE; returns the same way.
    task automatic run_commit(input stim_t s, input int ack_delay, input string tag);
        exp_t e;
        e = model(s);
        apply(s);
        cmt_i_valid = 1'b1;
        check({tag, ".ready_pre"}, 32'(cmt_i_ready), 32'd1);
        @(posedge clk); #1;
        check({tag, ".strb"}, 32'(strb), 32'(e.strb));
        if (e.trap) begin
            last_epc   = s.pc;
            last_cause = e.cause;
        end
        check({tag, ".epc"}, cmt_epc, last_epc);
        check({tag, ".cause"}, cmt_cause, last_cause);
        if (e.trap && !e.irq) check({tag, ".badaddr"}, cmt_badaddr, e.badaddr);
        check({tag, ".flush_req"}, 32'(pipe_flush_req), 32'(e.flush));
        check({tag, ".ready_n1"}, 32'(cmt_i_ready), 32'(!e.flush));
        if (e.flush) begin
            check({tag, ".flush_pc"}, pipe_flush_pc, e.flush_pc);
            for (int k = 0; k < ack_delay; k++) begin
                @(posedge clk); #1;
                check({tag, ".hold_req"}, 32'(pipe_flush_req), 32'd1);
                check({tag, ".hold_pc"}, pipe_flush_pc, e.flush_pc);
                check({tag, ".hold_ready"}, 32'(cmt_i_ready), 32'd0);
                check({tag, ".hold_strb"}, 32'(strb), 32'd0);
            end
            cmt_i_valid    = 1'b0;
            pipe_flush_ack = 1'b1;
            @(posedge clk); #1;
            pipe_flush_ack = 1'b0;
            check({tag, ".rel_req"}, 32'(pipe_flush_req), 32'd0);
            check({tag, ".rel_ready"}, 32'(cmt_i_ready), 32'd1);
            check({tag, ".rel_strb"}, 32'(strb), 32'd0);
        end else begin
            cmt_i_valid    = 1'b0;
            pipe_flush_ack = 1'b1;
            @(posedge clk); #1;
            pipe_flush_ack = 1'b0;
            check({tag, ".pulse_end"}, 32'(strb), 32'd0);
            check({tag, ".idle_req"}, 32'(pipe_flush_req), 32'd0);
            check({tag, ".idle_ready"}, 32'(cmt_i_ready), 32'd1);
        end
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.pc      = $urandom;
        s.badaddr = $urandom;
        s.mtvec   = $urandom;
        s.epc     = $urandom;
        s.ilegl   = ($urandom_range(0, 7) == 0);
        s.ebreak  = ($urandom_range(0, 7) == 0);
        s.ecall   = ($urandom_range(0, 7) == 0);
        s.ld      = ($urandom_range(0, 5) == 0);
        s.st      = ($urandom_range(0, 5) == 0);
        s.mret    = ($urandom_range(0, 3) == 0);
        s.ext     = ($urandom_range(0, 3) == 0);
        s.sft     = ($urandom_range(0, 3) == 0);
        s.tmr     = ($urandom_range(0, 3) == 0);
        s.mie     = $urandom_range(0, 1) == 1;
        s.meie    = $urandom_range(0, 1) == 1;
        s.msie    = $urandom_range(0, 1) == 1;
        s.mtie    = $urandom_range(0, 1) == 1;
        s.dbg     = ($urandom_range(0, 7) == 0);
        return s;
    endfunction

    stim_t base_s, s;

    initial begin
        base_s = '0;
        base_s.pc    = 32'h8000_0100;
        base_s.mtvec = 32'h8000_0000;
        rst = 1'b1;
        cmt_i_valid = 1'b0;
        pipe_flush_ack = 1'b0;
        apply(base_s);
        repeat (3) @(posedge clk);
        #1;
        check("rst.ready", 32'(cmt_i_ready), 32'd1);
        check("rst.strb", 32'(strb), 32'd0);
        check("rst.req", 32'(pipe_flush_req), 32'd0);
        check("rst.flush_pc", pipe_flush_pc, 32'd0);
        check("rst.epc", cmt_epc, 32'd0);
        check("rst.cause", cmt_cause, 32'd0);
        check("rst.badaddr", cmt_badaddr, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_commit(base_s, 0, "normal");

        s = base_s; s.ld = 1'b1; s.badaddr = 32'h8000_1003;
        run_commit(s, 2, "misalgn_ld");

        s = base_s; s.mie = 1'b1; s.meie = 1'b1; s.mtie = 1'b1; s.ext = 1'b1; s.tmr = 1'b1;
        s.ilegl = 1'b1; s.mtvec = 32'h8000_0001;
        run_commit(s, 0, "irq_vs_exc");

        s = base_s; s.mie = 1'b1; s.msie = 1'b1; s.mtie = 1'b1; s.sft = 1'b1; s.tmr = 1'b1;
        s.mtvec = 32'h8000_0001;
        run_commit(s, 1, "sft_irq");

        s = base_s; s.mret = 1'b1; s.epc = 32'h8000_0200;
        run_commit(s, 5, "mret_delay5");

        s = base_s; s.mret = 1'b1; s.ecall = 1'b1; s.epc = 32'h8000_0200;
        run_commit(s, 0, "mret_ecall");

        s = base_s; s.st = 1'b1; s.ebreak = 1'b1; s.badaddr = 32'h1234_5677;
        run_commit(s, 1, "multi_exc");

        s = base_s; s.dbg = 1'b1; s.mie = 1'b1; s.meie = 1'b1; s.ext = 1'b1;
        run_commit(s, 0, "dbg_mask");

        // Reset while a flush is outstanding
        s = base_s; s.ecall = 1'b1;
        apply(s);
        cmt_i_valid = 1'b1;
        @(posedge clk); #1;
        cmt_i_valid = 1'b0;
        check("rstflush.req_before", 32'(pipe_flush_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstflush.req", 32'(pipe_flush_req), 32'd0);
        check("rstflush.ready", 32'(cmt_i_ready), 32'd1);
        check("rstflush.cause", cmt_cause, 32'd0);
        last_epc = '0;
        last_cause = '0;
        @(posedge clk); #1;

        for (int n = 0; n < 200; n++) begin
            run_commit(rand_stim(), $urandom_range(0, 3), "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/e203_exu_trap_ctrl.md
# e203_exu_trap_ctrl

Commit-stage trap controller for the E203 execution unit. Sits directly upstream of `e203_exu_csr`. It accepts one committing instruction per handshake, resolves interrupts, exceptions and `mret`, and produces the `cmt_*` update strobes and the `nonflush_cmt_ena` strobe consumed by the CSR block. It also drives the pipeline-flush request toward the IFU and holds commit off until that flush is acknowledged.

## Interface
Parameters:
- `PC_SIZE`, 32, width of all PC, address and CSR value ports.

Ports:
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `cmt_i_valid` in 1: instruction presented for commit.
- `cmt_i_ready` out 1: commit accepted when valid & ready.
- `cmt_i_pc` in PC_SIZE: PC of the presented instruction.
- `cmt_i_ilegl`, `cmt_i_ebreak`, `cmt_i_ecall`, `cmt_i_misalgn_ld`, `cmt_i_misalgn_st` in 1 each: exception flags.
- `cmt_i_badaddr` in PC_SIZE: faulting address for misaligned accesses.
- `cmt_i_mret` in 1: instruction is `mret`.
- `ext_irq_r`, `sft_irq_r`, `tmr_irq_r` in 1 each: pending interrupt lines.
- `status_mie_r`, `mie_meie_r`, `mie_msie_r`, `mie_mtie_r` in 1 each: enable bits from the CSR block.
- `csr_mtvec_r`, `csr_epc_r` in PC_SIZE: current `mtvec` and `mepc`.
- `dbg_mode` in 1: core is in debug mode.
- `cmt_epc`, `cmt_badaddr`, `cmt_cause` out PC_SIZE: values to the CSR block.
- `cmt_epc_ena`, `cmt_badaddr_ena`, `cmt_cause_ena`, `cmt_status_ena`, `cmt_mret_ena`, `cmt_instret_ena`, `nonflush_cmt_ena` out 1: single-cycle CSR update strobes.
- `pipe_flush_req` out 1: flush request to the IFU.
- `pipe_flush_pc` out PC_SIZE: flush target address.
- `pipe_flush_ack` in 1: flush accepted.

## Operation
States: IDLE and FLUSH_WAIT. `cmt_i_ready` = (state == IDLE), decoded combinationally from the state register.

Interrupt selection, evaluated at each accepted commit:
- An interrupt is taken only if `status_mie_r` = 1 and `dbg_mode` = 0.
- Priority is ext (code 11), then sft (code 3), then tmr (code 7). Each line is qualified by its matching `mie_*` bit.
- A taken interrupt is attached to the committing instruction. That instruction does not retire: epc = `cmt_i_pc`, cause = {1, 27'b0, code}.

Exception selection, when no interrupt is taken:
- Priority is ilegl (2), ebreak (3), ecall (11), misalgn_ld (4), misalgn_st (6).
- cause = {0, 27'b0, code}.
- badaddr = `cmt_i_badaddr` for misaligned exceptions, otherwise 0. The instruction does not retire.

`mret`, when there is no trap: the instruction retires and the flush target is `csr_epc_r`, sampled at acceptance.

Any other instruction retires with no flush.

Trap response (interrupt or exception), in the cycle after acceptance:
- `cmt_epc_ena`, `cmt_cause_ena` and `cmt_status_ena` pulse for one cycle.
- `cmt_badaddr_ena` also pulses, for exceptions only.
- Flush target = {`csr_mtvec_r`[31:2], 2'b00}.
- State moves to FLUSH_WAIT.

`mret` response:
- `cmt_mret_ena`, `cmt_instret_ena` and `nonflush_cmt_ena` pulse.
- State moves to FLUSH_WAIT.

Normal retire:
- `cmt_instret_ena` and `nonflush_cmt_ena` pulse.
- State stays in IDLE.

FLUSH_WAIT:
- `pipe_flush_req` = 1 and `pipe_flush_pc` is held constant.
- When `pipe_flush_ack` = 1, state returns to IDLE and `pipe_flush_req` drops the following cycle.
- `pipe_flush_ack` is ignored in IDLE.

Simultaneous events:
- Interrupt plus exception: the interrupt wins.
- Exception plus `mret`: the exception wins, and no `cmt_mret_ena` is produced.
- Several exception flags: only the highest-priority flag is reported.

## Timing
- Acceptance in cycle N; all `cmt_*` outputs are registered and valid in N+1 only. `cmt_epc`, `cmt_cause` and `cmt_badaddr` hold their value until the next trap.
- `pipe_flush_req` rises in N+1. The earliest possible ack is in N+1.
- `cmt_i_ready` is 0 from N+1 through the ack cycle, and returns to 1 in the cycle after the ack.
- No new commit is accepted while in FLUSH_WAIT.
- Reset values: state = IDLE, `cmt_i_ready` = 1, all strobes 0, `pipe_flush_req` = 0, `pipe_flush_pc` = 0, `cmt_epc`/`cmt_cause`/`cmt_badaddr` = 0.
- Reset in FLUSH_WAIT abandons the flush: `pipe_flush_req` = 0 in the cycle after reset is sampled.

## Configuration
- `E203_TRAP_VECTORED_EN` defined: when `csr_mtvec_r`[0] = 1, the interrupt flush target is base + 4 × code. Exceptions always use base.
- `E203_TRAP_VECTORED_EN` undefined: every trap targets base and `csr_mtvec_r`[1:0] is ignored.

## Test plan
- **Normal commit:** plain instruction at pc 0x80000100 -> `cmt_instret_ena` = `nonflush_cmt_ena` = 1 in N+1, no flush, `cmt_i_ready` stays 1.
- **Misaligned load:** misalgn_ld, badaddr 0x80001003, `csr_mtvec_r` 0x80000000 -> in N+1 cause 0x4, epc = pc, badaddr 0x80001003, flush_pc 0x80000000; `cmt_i_ready` = 0 until ack.
- **Interrupt vs exception:** mie/meie = 1, ext_irq_r and tmr_irq_r high, plus ilegl, `csr_mtvec_r` 0x80000001 -> cause 0x8000000B, `cmt_badaddr_ena` = 0. Flush_pc is 0x8000002C with the macro, 0x80000000 without.
- **`mret`:** `csr_epc_r` 0x80000200 -> `cmt_mret_ena` and `cmt_instret_ena` pulse, flush_pc 0x80000200. With mret plus ecall, cause 0xB is reported and there is no `cmt_mret_ena`.
- **Debug masking and delayed ack:** `dbg_mode` = 1 with an irq pending -> no trap. Ack delayed 5 cycles -> `pipe_flush_req` holds with a stable pc, then releases one cycle after the ack.
- **Reset mid-flush:** `rst` asserted in FLUSH_WAIT -> next cycle `pipe_flush_req` = 0 and `cmt_i_ready` = 1.
